// File: rtl/wb_dual_master_arbiter_if.sv
// Purpose: one point-to-point Wishbone classic link (request, write data, read data, ack).
// Latency: none, this is wiring only.
// Backpressure: the slave side stalls the master by withholding ack.
// Ports: modport master drives cyc/stb/we/sel/adr/wr_dat and samples rd_dat/ack;
//        modport slave is the mirror image.
interface wb_dual_master_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] sel;
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   wr_dat;
  logic [DATA_WIDTH-1:0]   rd_dat;
  logic                    ack;

  modport master (output cyc, stb, we, sel, adr, wr_dat, input rd_dat, ack);
  modport slave  (input cyc, stb, we, sel, adr, wr_dat, output rd_dat, ack);
endinterface

// File: rtl/wb_dual_master_arbiter.sv
// Purpose: round-robin merge of an instruction master (m0) and a data master (m1) onto one Wishbone slave.
// Latency: request seen in IDLE at cycle N gives s.stb at N+1; slave ack is forwarded in the same cycle.
// Backpressure: the losing master waits with ack low; a silent slave is cut off after TIMEOUT_CYCLES.
// Ports: clk_i/rst_i (sync, active-high); m0, m1 = slave-side links from the masters;
//        s = master-side link to the slave bus; timeout_o = one-cycle pulse on forced termination.
module wb_dual_master_arbiter #(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  wb_dual_master_arbiter_if.slave         m0,
  wb_dual_master_arbiter_if.slave         m1,
  wb_dual_master_arbiter_if.master        s,
  output logic                            timeout_o
);
  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_M0 = 2'd1,
    BUSY_M1 = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    last_m1_q, last_m1_d;   // 1: m1 held the most recent grant
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [SEL_WIDTH-1:0]    sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;

  logic                    m0_req, m1_req, pick_m1;
  logic                    busy, gnt_cyc, tmo_hit, fwd_ack, tmo_fire;
  logic [DATA_WIDTH-1:0]   rsp_dat;

  assign m0_req  = m0.cyc & m0.stb;
  assign m1_req  = m1.cyc & m1.stb;
  // On a tie the master that did not win last time gets the bus.
  assign pick_m1 = m1_req & (~m0_req | ~last_m1_q);

  assign busy    = (state_q == BUSY_M0) | (state_q == BUSY_M1);
  // A granted master that drops cyc aborts; nothing is forwarded to it that cycle.
  assign gnt_cyc = ((state_q == BUSY_M0) & m0.cyc) | ((state_q == BUSY_M1) & m1.cyc);
  assign tmo_hit = busy & (cnt_q == CNT_MAX);
  assign fwd_ack = gnt_cyc & s.ack;
  // A real ack on the last allowed cycle wins over the timeout.
  assign tmo_fire = gnt_cyc & ~s.ack & tmo_hit;
  assign rsp_dat  = tmo_fire ? TIMEOUT_DATA : s.rd_dat;

  // State and request registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      last_m1_q <= 1'b0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_m1_q <= last_m1_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
    end
  end

  // Next state: grant in IDLE, leave BUSY on ack, abort or timeout.
  always_comb begin
    state_d   = state_q;
    last_m1_d = last_m1_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    case (state_q)
      IDLE: begin
        if (m0_req | m1_req) begin
          state_d   = pick_m1 ? BUSY_M1 : BUSY_M0;
          last_m1_d = pick_m1;
          cnt_d     = '0;
          we_d      = pick_m1 ? m1.we     : m0.we;
          sel_d     = pick_m1 ? m1.sel    : m0.sel;
          adr_d     = pick_m1 ? m1.adr    : m0.adr;
          dat_d     = pick_m1 ? m1.wr_dat : m0.wr_dat;
        end
      end
      BUSY_M0, BUSY_M1: begin
        if (!gnt_cyc || s.ack || tmo_hit) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: the slave sees only latched request fields; responses go to the granted master only.
  always_comb begin
    s.cyc     = 1'b0;
    s.stb     = 1'b0;
    s.we      = 1'b0;
    s.sel     = '0;
    s.adr     = '0;
    s.wr_dat  = '0;
    m0.ack    = 1'b0;
    m0.rd_dat = '0;
    m1.ack    = 1'b0;
    m1.rd_dat = '0;
    timeout_o = 1'b0;
    if (busy) begin
      s.cyc     = 1'b1;
      s.stb     = 1'b1;
      s.we      = we_q;
      s.sel     = sel_q;
      s.adr     = adr_q;
      s.wr_dat  = dat_q;
      timeout_o = tmo_fire;
    end
    if (state_q == BUSY_M0) begin
      m0.ack    = fwd_ack | tmo_fire;
      m0.rd_dat = rsp_dat;
    end
    if (state_q == BUSY_M1) begin
      m1.ack    = fwd_ack | tmo_fire;
      m1.rd_dat = rsp_dat;
    end
  end
endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
module tb_wb_dual_master_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic timeout_o;

  always #5 clk_i = ~clk_i;

  wb_dual_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_bus ();
  wb_dual_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_bus ();
  wb_dual_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_bus ();

  wb_dual_master_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO), .TIMEOUT_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .m0(m0_bus), .m1(m1_bus), .s(s_bus), .timeout_o(timeout_o)
  );

  typedef struct { logic we; logic [3:0] sel; logic [31:0] adr; logic [31:0] wdat; } req_t;
  typedef struct { int m; logic we; logic [3:0] sel; logic [31:0] adr; logic [31:0] wdat;
                   logic [31:0] rdat; logic tmo; } exp_t;

  req_t m0_pend[$];   // requests each master issues in order; front is the one on the bus
  req_t m1_pend[$];
  exp_t sb[$];        // expected completions in grant order
  int   rises[$];     // cycles where s.stb rose
  int   acks[$];      // cycles where a master saw ack

  int   n_chk = 0, n_pass = 0, n_fail = 0;
  int   cyc_n = 0, stb_cnt = 0, slv_lat = 1, req_start = 0;
  bit   slv_en = 0, slv_fixed = 0, slv_stray = 0, any_req_prev = 0;
  bit   ack0_seen = 0, ack1_seen = 0;
  logic [31:0] slv_rdat = '0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic int at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_masters();
    bit any;
    if (m0_pend.size() > 0) begin
      m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.we = m0_pend[0].we;
      m0_bus.sel = m0_pend[0].sel; m0_bus.adr = m0_pend[0].adr; m0_bus.wr_dat = m0_pend[0].wdat;
    end else begin
      m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0; m0_bus.we = 1'b0;
      m0_bus.sel = '0; m0_bus.adr = '0; m0_bus.wr_dat = '0;
    end
    if (m1_pend.size() > 0) begin
      m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1; m1_bus.we = m1_pend[0].we;
      m1_bus.sel = m1_pend[0].sel; m1_bus.adr = m1_pend[0].adr; m1_bus.wr_dat = m1_pend[0].wdat;
    end else begin
      m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0; m1_bus.we = 1'b0;
      m1_bus.sel = '0; m1_bus.adr = '0; m1_bus.wr_dat = '0;
    end
    any = (m0_pend.size() > 0) || (m1_pend.size() > 0);
    if (any && !any_req_prev) req_start = cyc_n;
    any_req_prev = any;
  endtask

  task automatic monitor();
    exp_t e;
    ack0_seen = m0_bus.ack;
    ack1_seen = m1_bus.ack;
    if (m0_bus.ack || m1_bus.ack) begin
      acks.push_back(cyc_n);
      if (sb.size() == 0) begin
        chk("unexpected_ack", {30'b0, m1_bus.ack, m0_bus.ack}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_owner", {30'b0, m1_bus.ack, m0_bus.ack}, (e.m != 0) ? 32'd2 : 32'd1);
        chk("s_adr", s_bus.adr, e.adr);
        chk("s_we", 32'(s_bus.we), 32'(e.we));
        chk("s_sel", 32'(s_bus.sel), 32'(e.sel));
        if (e.we) chk("s_wr_dat", s_bus.wr_dat, e.wdat);
        chk("rd_dat", (e.m != 0) ? m1_bus.rd_dat : m0_bus.rd_dat, e.rdat);
        chk("other_rd_dat", (e.m != 0) ? m0_bus.rd_dat : m1_bus.rd_dat, 32'd0);
        chk("timeout_flag", 32'(timeout_o), 32'(e.tmo));
      end
    end else begin
      chk("timeout_without_ack", 32'(timeout_o), 32'd0);
    end
  endtask

  // One clock: drive masters and slave just after the edge, sample at the falling edge.
  task automatic tick();
    @(posedge clk_i);
    cyc_n++;
    #1;
    if (ack0_seen && m0_pend.size() > 0) void'(m0_pend.pop_front());
    if (ack1_seen && m1_pend.size() > 0) void'(m1_pend.pop_front());
    ack0_seen = 1'b0;
    ack1_seen = 1'b0;
    drive_masters();
    if (s_bus.stb) begin
      stb_cnt++;
      if (stb_cnt == 1) rises.push_back(cyc_n);
    end else begin
      stb_cnt = 0;
    end
    s_bus.ack    = slv_stray || (slv_en && s_bus.stb && (stb_cnt == slv_lat));
    s_bus.rd_dat = slv_fixed ? slv_rdat : mem_rd(s_bus.adr);
    @(negedge clk_i);
    monitor();
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_drained"}, sb.size(), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ctl"}, {22'b0, s_bus.cyc, s_bus.stb, s_bus.we, s_bus.sel,
                        m0_bus.ack, m1_bus.ack, timeout_o}, 32'd0);
    chk({tag, "_s_adr"}, s_bus.adr, 32'd0);
    chk({tag, "_s_wr_dat"}, s_bus.wr_dat, 32'd0);
    chk({tag, "_m0_rd_dat"}, m0_bus.rd_dat, 32'd0);
    chk({tag, "_m1_rd_dat"}, m1_bus.rd_dat, 32'd0);
  endtask

  task automatic reset_dut();
    rst_i = 1'b1;
    m0_pend.delete(); m1_pend.delete(); sb.delete(); rises.delete(); acks.delete();
    slv_en = 0; slv_fixed = 0; slv_stray = 0; slv_lat = 1;
    tick();
    tick();
    check_idle("in_reset");
    rst_i = 1'b0;
  endtask

  initial begin
    req_t r;
    exp_t e;
    drive_masters();
    s_bus.ack = 1'b0;
    s_bus.rd_dat = '0;

    // Reset values, and a stray slave ack in IDLE goes nowhere.
    reset_dut();
    slv_stray = 1;
    tick();
    check_idle("stray_ack_idle");
    slv_stray = 0;

    // M0 alone: read 0x100, slave acks on the second stb cycle.
    reset_dut();
    slv_en = 1; slv_lat = 2; slv_fixed = 1; slv_rdat = 32'h1234_5678;
    m0_pend.push_back('{we: 1'b0, sel: 4'hF, adr: 32'h100, wdat: 32'h0});
    sb.push_back('{m: 0, we: 1'b0, sel: 4'hF, adr: 32'h100, wdat: 32'h0, rdat: 32'h1234_5678, tmo: 1'b0});
    drain("m0_only", 20);
    chk("m0_req_to_stb", at(rises, 0) - req_start, 32'd1);
    chk("m0_stb_to_ack", at(acks, 0) - at(rises, 0), 32'd1);
    tick();
    chk("m0_ack_one_cycle", 32'(m0_bus.ack), 32'd0);
    chk("m0_idle_after_ack", 32'(s_bus.stb), 32'd0);

    // Tie right after reset: M1 write wins, M0 read follows two cycles after M1's ack.
    reset_dut();
    slv_en = 1; slv_lat = 1;
    m0_pend.push_back('{we: 1'b0, sel: 4'hF, adr: 32'h0, wdat: 32'h0});
    m1_pend.push_back('{we: 1'b1, sel: 4'b0011, adr: 32'h200, wdat: 32'hAABB_CCDD});
    sb.push_back('{m: 1, we: 1'b1, sel: 4'b0011, adr: 32'h200, wdat: 32'hAABB_CCDD, rdat: mem_rd(32'h200), tmo: 1'b0});
    sb.push_back('{m: 0, we: 1'b0, sel: 4'hF, adr: 32'h0, wdat: 32'h0, rdat: mem_rd(32'h0), tmo: 1'b0});
    drain("tie", 30);
    chk("zero_wait_latency", at(acks, 0) - req_start, 32'd1);
    chk("tie_regrant_gap", at(rises, 1) - at(acks, 0), 32'd2);

    // Fairness: both masters keep requesting for 8 transactions.
    reset_dut();
    slv_en = 1; slv_lat = 1;
    for (int i = 0; i < 4; i++) begin
      r.we = i[0]; r.sel = 4'hF; r.adr = 32'h1000 + 32'(4 * i); r.wdat = 32'h1111_0000 + 32'(i);
      m1_pend.push_back(r);
      e.m = 1; e.we = r.we; e.sel = r.sel; e.adr = r.adr; e.wdat = r.wdat; e.rdat = mem_rd(r.adr); e.tmo = 1'b0;
      sb.push_back(e);
      r.we = ~i[0]; r.sel = 4'b1100; r.adr = 32'h2000 + 32'(4 * i); r.wdat = 32'h2222_0000 + 32'(i);
      m0_pend.push_back(r);
      e.m = 0; e.we = r.we; e.sel = r.sel; e.adr = r.adr; e.wdat = r.wdat; e.rdat = mem_rd(r.adr);
      sb.push_back(e);
    end
    drain("fair", 100);
    for (int i = 0; i < 7; i++) chk("fair_gap", at(rises, i + 1) - at(acks, i), 32'd2);

    // Timeout: silent slave, M1 read terminated on the TMO-th stb cycle.
    reset_dut();
    m1_pend.push_back('{we: 1'b0, sel: 4'hF, adr: 32'h300, wdat: 32'h0});
    sb.push_back('{m: 1, we: 1'b0, sel: 4'hF, adr: 32'h300, wdat: 32'h0, rdat: 32'hDEAD_BEEF, tmo: 1'b1});
    drain("timeout", 40);
    chk("timeout_stb_cycles", at(acks, 0) - at(rises, 0) + 1, TMO);
    tick();
    chk("timeout_then_idle", 32'(s_bus.stb), 32'd0);

    // Real ack on the last allowed cycle beats the timeout.
    reset_dut();
    slv_en = 1; slv_lat = TMO; slv_fixed = 1; slv_rdat = 32'h55;
    m1_pend.push_back('{we: 1'b0, sel: 4'hF, adr: 32'h304, wdat: 32'h0});
    sb.push_back('{m: 1, we: 1'b0, sel: 4'hF, adr: 32'h304, wdat: 32'h0, rdat: 32'h55, tmo: 1'b0});
    drain("late_ack", 40);
    chk("late_ack_stb_cycles", at(acks, 0) - at(rises, 0) + 1, TMO);

    // Abort: M0 drops cyc in the very cycle the slave acks.
    reset_dut();
    slv_en = 1; slv_lat = 3;
    m0_pend.push_back('{we: 1'b0, sel: 4'hF, adr: 32'h400, wdat: 32'h0});
    tick(); tick(); tick();
    chk("abort_pre_stb", 32'(s_bus.stb), 32'd1);
    m0_pend.delete();
    tick();
    chk("abort_ack_blocked", 32'(m0_bus.ack), 32'd0);
    tick();
    chk("abort_cyc_dropped", 32'(s_bus.cyc), 32'd0);

    // Reset during BUSY_M1, with the slave's ack arriving late.
    reset_dut();
    m1_pend.push_back('{we: 1'b0, sel: 4'hF, adr: 32'h500, wdat: 32'h0});
    tick(); tick(); tick();
    chk("rst_pre_busy", 32'(s_bus.stb), 32'd1);
    rst_i = 1'b1;
    slv_stray = 1;
    tick();
    check_idle("rst_mid_busy");
    m1_pend.delete();
    tick();
    rst_i = 1'b0;
    tick();
    check_idle("rst_after_release");
    slv_stray = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
